// File: rtl/sampler_and_buffer_writer.sv
// Sample-tick edge capture into ping-pong sample banks.
// Pulses start_round when a bank fills; holds off while the estimator is busy.
module sampler_and_buffer_writer #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f0_done,
    input  logic [DATA_W-1:0] data,
    input  logic              sample_tick,
    output logic              start_round,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] out,
    output logic              now_writing,
    output logic [1:0]        en
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              tick_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              bank_q, bank_d;
    logic              start_round_q, start_round_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              now_writing_q, now_writing_d;
    logic [1:0]        en_q, en_d;
    logic              tick_edge;
    logic              ptr_last;

    assign tick_edge = sample_tick & ~tick_q;
    assign ptr_last  = (ptr_q == {ADDR_W{1'b1}});

    // Next-state: capture on tick edge, handle bank completion and hold-off.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        bank_d        = bank_q;
        start_round_d = 1'b0;
        addr_d        = addr_q;
        out_d         = out_q;
        now_writing_d = 1'b0;
        en_d          = 2'b00;
        unique case (state_q)
            FILL: begin
                if (tick_edge) begin
                    now_writing_d = 1'b1;
                    en_d          = bank_q ? 2'b10 : 2'b01;
                    addr_d        = ptr_q;
                    out_d         = data;
                    ptr_d         = ptr_q + 1'b1;
                    if (ptr_last) begin
                        if (f0_done) begin
                            start_round_d = 1'b1;
                            bank_d        = ~bank_q;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (f0_done) begin
                    start_round_d = 1'b1;
                    bank_d        = ~bank_q;
                    ptr_d         = '0;
                    state_d       = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State and registered outputs; reset abandons any partial bank.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= FILL;
            tick_q        <= 1'b0;
            ptr_q         <= '0;
            bank_q        <= 1'b0;
            start_round_q <= 1'b0;
            addr_q        <= '0;
            out_q         <= '0;
            now_writing_q <= 1'b0;
            en_q          <= 2'b00;
        end else begin
            state_q       <= state_d;
            tick_q        <= sample_tick;
            ptr_q         <= ptr_d;
            bank_q        <= bank_d;
            start_round_q <= start_round_d;
            addr_q        <= addr_d;
            out_q         <= out_d;
            now_writing_q <= now_writing_d;
            en_q          <= en_d;
        end
    end

    assign start_round = start_round_q;
    assign Addr        = addr_q;
    assign out         = out_q;
    assign now_writing = now_writing_q;
    assign en          = en_q;

endmodule

// File: tb/tb_sampler_and_buffer_writer.sv
// Directed bench for sampler_and_buffer_writer.
// Vector table for short cases, hand sequences for bank rollover and hold.
module tb_sampler_and_buffer_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f0_done;
    logic [11:0] data;
    logic        sample_tick;
    logic        start_round;
    logic [10:0] Addr;
    logic [11:0] out;
    logic        now_writing;
    logic [1:0]  en;

    always #5 clk = ~clk;

    sampler_and_buffer_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f0_done     (f0_done),
        .data        (data),
        .sample_tick (sample_tick),
        .start_round (start_round),
        .Addr        (Addr),
        .out         (out),
        .now_writing (now_writing),
        .en          (en)
    );

    typedef struct {
        logic        rst_n;
        logic        f0;
        logic        tick;
        logic [11:0] data;
        logic        sr;
        logic [10:0] addr;
        logic [11:0] out;
        logic        nw;
        logic [1:0]  en;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // model of the write stream for long runs
    int          exp_ptr;
    int          exp_bank;
    int          errs;
    int          nwr;
    int          nsr;
    logic [11:0] last_data;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        sample_tick = 1'b0;
        f0_done     = 1'b1;
        data        = 12'h000;
        step();
        step();
        rst_n    = 1'b1;
        exp_ptr  = 0;
        exp_bank = 0;
        errs     = 0;
        nwr      = 0;
        nsr      = 0;
    endtask

    task automatic watch();
        if (now_writing) begin
            nwr++;
            if (Addr !== exp_ptr[10:0]) errs++;
            if (en !== (exp_bank != 0 ? 2'b10 : 2'b01)) errs++;
            if (out !== last_data) errs++;
            if (start_round !== ((exp_ptr == 2047) && f0_done)) errs++;
            if (start_round) nsr++;
            if (exp_ptr == 2047) begin
                exp_ptr = 0;
                if (f0_done) exp_bank = 1 - exp_bank;
            end else begin
                exp_ptr++;
            end
        end else begin
            if (en !== 2'b00) errs++;
            if (start_round) begin
                nsr++;
                errs++;
            end
        end
    endtask

    task automatic fast_cycle(input logic f0);
        sample_tick = ~sample_tick;
        data        = data + 12'd7;
        f0_done     = f0;
        last_data   = data;
        step();
        watch();
    endtask

    task automatic run_writes(input int n, input logic f0);
        int target;
        int budget;
        target = nwr + n;
        budget = 4 * n + 16;
        while (nwr < target && budget > 0) begin
            fast_cycle(f0);
            budget--;
        end
    endtask

    vec_t vt[11];

    initial begin
        int k;
        int wr;
        int nw_prev;
        logic [11:0] prev_out;
        int n0;
        int s0;

        vt[0]  = '{1'b0, 1'b1, 1'b1, 12'h005, 1'b0, 11'd0, 12'h000, 1'b0, 2'b00};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 12'h006, 1'b0, 11'd0, 12'h000, 1'b0, 2'b00};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 12'h123, 1'b0, 11'd0, 12'h123, 1'b1, 2'b01};
        vt[3]  = '{1'b1, 1'b1, 1'b1, 12'h456, 1'b0, 11'd0, 12'h123, 1'b0, 2'b00};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 12'h777, 1'b0, 11'd0, 12'h123, 1'b0, 2'b00};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 12'h888, 1'b0, 11'd0, 12'h123, 1'b0, 2'b00};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 12'hABC, 1'b0, 11'd1, 12'hABC, 1'b1, 2'b01};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 12'hFFF, 1'b0, 11'd1, 12'hABC, 1'b0, 2'b00};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 12'hFFF, 1'b0, 11'd2, 12'hFFF, 1'b1, 2'b01};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 12'h111, 1'b0, 11'd0, 12'h000, 1'b0, 2'b00};
        vt[10] = '{1'b1, 1'b1, 1'b1, 12'h001, 1'b0, 11'd0, 12'h001, 1'b1, 2'b01};

        rst_n       = 1'b0;
        f0_done     = 1'b1;
        sample_tick = 1'b0;
        data        = 12'h000;

        // table: reset, edge capture, level hold, mid-stream reset
        for (int i = 0; i < 11; i++) begin
            rst_n       = vt[i].rst_n;
            f0_done     = vt[i].f0;
            sample_tick = vt[i].tick;
            data        = vt[i].data;
            step();
            check($sformatf("v%0d_sr", i), start_round, vt[i].sr);
            check($sformatf("v%0d_addr", i), Addr, vt[i].addr);
            check($sformatf("v%0d_out", i), out, vt[i].out);
            check($sformatf("v%0d_nw", i), now_writing, vt[i].nw);
            check($sformatf("v%0d_en", i), en, vt[i].en);
        end

        // divider num=16: rising tick every 32 clk, data counts clocks
        do_reset();
        wr      = 0;
        nw_prev = 0;
        prev_out = 12'h000;
        k = 0;
        while (wr < 6 && k < 400) begin
            sample_tick = ((k / 16) % 2) != 0;
            data        = k[11:0];
            step();
            if (now_writing && nw_prev != 0) errs++;
            if (now_writing) begin
                check("div_addr", Addr, wr);
                check("div_en", en, 2'b01);
                if (wr > 0) check("div_step", out - prev_out, 12'd32);
                prev_out = out;
                wr++;
            end
            nw_prev = now_writing;
            k++;
        end
        check("div_count", wr, 6);
        check("div_width", errs, 0);

        // fast tick, estimator ready: bank0 -> bank1 -> bank0
        do_reset();
        run_writes(2048, 1'b1);
        check("fast_b0_writes", nwr, 2048);
        check("fast_b0_sr", nsr, 1);
        run_writes(1, 1'b1);
        check("fast_b1_first_en", en, 2'b10);
        check("fast_b1_first_addr", Addr, 0);
        run_writes(2047, 1'b1);
        check("fast_b1_sr", nsr, 2);
        run_writes(1, 1'b1);
        check("fast_b0_again_en", en, 2'b01);
        check("fast_errs", errs, 0);

        // estimator busy at end of bank0: hold, then release
        do_reset();
        run_writes(2048, 1'b0);
        check("hold_fill", nwr, 2048);
        check("hold_no_sr", nsr, 0);
        n0 = nwr;
        s0 = nsr;
        for (int i = 0; i < 20; i++) fast_cycle(1'b0);
        check("hold_no_write", nwr, n0);
        check("hold_no_sr2", nsr, s0);
        sample_tick = 1'b0;
        f0_done     = 1'b0;
        step();
        sample_tick = 1'b1;
        f0_done     = 1'b1;
        step();
        check("exit_sr", start_round, 1'b1);
        check("exit_nw", now_writing, 1'b0);
        step();
        check("exit_sr_once", start_round, 1'b0);
        check("exit_edge_ignored", now_writing, 1'b0);
        exp_bank = 1;
        exp_ptr  = 0;
        sample_tick = 1'b1;
        run_writes(1, 1'b1);
        check("resume_en", en, 2'b10);
        check("resume_addr", Addr, 0);

        // reset partway through bank1
        k = 0;
        while (exp_ptr != 1001 && k < 5000) begin
            fast_cycle(1'b1);
            k++;
        end
        check("mid_addr", Addr, 1000);
        check("mid_errs", errs, 0);
        rst_n = 1'b0;
        step();
        check("mid_rst_sr", start_round, 1'b0);
        check("mid_rst_en", en, 2'b00);
        check("mid_rst_addr", Addr, 0);
        rst_n       = 1'b1;
        sample_tick = 1'b0;
        exp_bank    = 0;
        exp_ptr     = 0;
        errs        = 0;
        run_writes(1, 1'b1);
        check("post_rst_en", en, 2'b01);
        check("post_rst_addr", Addr, 0);
        check("post_rst_errs", errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sampler_and_buffer_writer.md
Name: sampler_and_buffer_writer

Overview:
Front-end sampler of the pitch-estimation pipeline. It captures one 12-bit ADC word per rising edge of an external sample tick and writes it into one of two 2048-entry ping-pong sample buffers. When a buffer is full it pulses start_round to launch the F0 estimator on that buffer, then continues on the other buffer. The sample tick comes from the companion clock_divider, a square wave that toggles every `num` clk cycles.

Parameters:
DATA_W, 12, sample width
ADDR_W, 11, buffer address width; buffer depth = 2**ADDR_W = 2048

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
f0_done  input  1  estimator idle/finished; 1 = the bank it last read may be overwritten
data  input  12  ADC sample word
sample_tick  input  1  sampling strobe (square wave); a capture happens on its rising edge
start_round  output  1  one-cycle pulse: the bank just filled is ready for the estimator
Addr  output  11  buffer write address
out  output  12  buffer write data
now_writing  output  1  one-cycle write strobe
en  output  2  bank write enable, one-hot: 2'b01 = bank0, 2'b10 = bank1, 2'b00 = no write

Behaviour:
- One clock; reset is synchronous and active-low. All state updates on posedge clk only.
- Reset values: start_round=0, Addr=0, out=0, now_writing=0, en=2'b00, write pointer=0, active bank=0, tick_q=0, state=FILL.
- Edge detect: tick_q <= sample_tick every cycle. edge = sample_tick & ~tick_q. A level held high counts once.
- State FILL, on the clock where edge=1:
  - Next cycle: now_writing=1, en=one-hot(active bank), Addr=ptr, out=data sampled at that clock. This is a 1-cycle latency from edge detection.
  - ptr <= ptr+1.
  - All write outputs return to 0 / 2'b00 the following cycle. Addr and out hold their last value.
- End of bank: when the write to ptr=2047 is issued, ptr wraps to 0 and the bank is complete.
  - If f0_done=1 on that clock: start_round pulses 1 cycle, coincident with the final write strobe. Active bank toggles. Stay in FILL.
  - If f0_done=0: enter HOLD.
- State HOLD:
  - Sample-tick edges are ignored; samples are dropped.
  - First clock with f0_done=1: start_round pulses the next cycle, active bank toggles, return to FILL with ptr=0.
- Rounds alternate bank0, bank1, bank0, … starting from bank0 after reset. The estimator tracks parity from start_round.
- An edge on the same clock as the HOLD exit is ignored. The first write after HOLD requires a later edge.
- Reset mid-fill: the partial bank is abandoned, no start_round is issued, and writing restarts at bank0, Addr 0.
- data is never modified, only sampled. out is a 12-bit copy with no arithmetic.
- Never assert two en bits at once. Never pulse start_round more than once per completed bank.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with sample_tick toggling -> all outputs 0, en=2'b00, no writes.
- Tick from clock_divider num=16, data incrementing every clk -> one write every 32 clk. Addr steps 0,1,2,… and consecutive out values differ by 32 mod 4096. now_writing is exactly 1 cycle wide, en=2'b01.
- Tick high for many cycles (level) -> exactly one write per rising edge.
- Fast tick (num=1), f0_done=1 -> after 2048 writes, start_round pulses once with Addr=2047. The next write has Addr=0, en=2'b10. After a further 2048 writes, en returns to 2'b01.
- f0_done=0 at end of bank0 -> no start_round, no writes while ticks continue. Raise f0_done -> start_round pulses 1 cycle, then writes resume at bank1, Addr 0.
- Assert rst_n=0 at Addr=1000 -> no start_round. The next write is bank0 (en=2'b01), Addr 0.
